chip8_timers: RTL and testbench
===============================

CHIP8_TIMERS -- requirements
Module: chip8_timers

Interface
REQ-001 SHALL have parameter TONE_HALF, default 5519: clk cycles per speaker half-period, about 440 Hz at a 4.857 MHz clk.
REQ-002 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port vsync, input, 1: hvsync frame sync; its rising edge is the 60 Hz timer tick source.
REQ-005 SHALL have port dt_we, input, 1: write strobe; loads wdata into the delay timer.
REQ-006 SHALL have port st_we, input, 1: write strobe; loads wdata into the sound timer.
REQ-007 SHALL have port wdata, input, 8: timer load value from the cpu.
REQ-008 SHALL have port dt_value, output, 8: current delay timer, read by the cpu (FX07).
REQ-009 SHALL have port st_value, output, 8: current sound timer.
REQ-010 SHALL have port beep, output, 1: high while st_value is nonzero.
REQ-011 SHALL have port spkr, output, 1: speaker drive.

Function
REQ-012 SHALL register vsync once; tick = vsync high and registered copy low, a 1-cycle pulse in the cycle after the rising edge is sampled.
REQ-013 SHALL, on tick, decrement each timer that is nonzero; a zero timer stays at 0, with no wrap to 255.
REQ-014 SHALL make a write (dt_we/st_we) take priority over a same-cycle tick decrement for that timer; the written value appears on the output the next cycle, undecremented.
REQ-015 SHALL treat the two timers independently; simultaneous dt_we and st_we both load wdata.
REQ-016 SHALL drive dt_value and st_value directly from their registers, with zero extra latency.
REQ-017 SHALL derive beep combinationally from the st register as (st != 0).
REQ-018 SHALL implement a tone state machine with states IDLE and TONE:
- IDLE -> TONE when beep = 1.
- TONE -> IDLE when beep = 0.
REQ-019 SHALL, in TONE, count a 16-bit counter 0..TONE_HALF-1 and, at the terminal count, toggle spkr and return the counter to 0.
REQ-020 SHALL, in IDLE, hold the counter at 0 and spkr at 0; spkr reaches 0 within 1 cycle of beep falling.
REQ-021 SHALL restart the tone phase from 0 with spkr = 0 on each IDLE -> TONE transition; a write that changes st_value from nonzero to nonzero does not restart the phase.
REQ-022 SHALL, if TONE_HALF < 2, clamp it to 2.

Reset
REQ-023 SHALL, with reset low, asynchronously force dt = 0, st = 0, counter = 0, spkr = 0 and state IDLE.
REQ-024 SHALL, with reset low, asynchronously force the vsync history register to 1, so vsync already high at release produces no tick.
REQ-025 SHALL, on reset asserted mid-tone or mid-countdown, abandon all state immediately; outputs are 0 while reset is low.
REQ-026 SHALL ignore writes and ticks while reset is low.

Configuration
REQ-027 SHALL use the macro CHIP8_TIMERS_TONE_EN.
- When defined: spkr is the square wave per REQ-018..REQ-021.
- When undefined: spkr = beep, and the tone counter and state machine are not synthesized.

Structure
REQ-028 SHALL place TIMER_W = 8, TONE_CNT_W = 16, the default TONE_HALF and the tone state enum (IDLE, TONE) in shared package chip8_pkg.
REQ-029 SHALL implement the vsync edge detector as sub-module tick_gen, with ports clk, reset, vsync and tick.

Verification
REQ-030 SHALL cover: release reset with vsync = 1 -> no tick; dt_value = 0, spkr = 0.
REQ-031 SHALL cover: dt_we with wdata = 3, then 4 vsync rising edges -> dt_value 3, 2, 1, 0, 0; no wrap.
REQ-032 SHALL cover: dt_we with wdata = 10 in the same cycle as tick -> dt_value = 10 next cycle; 9 after the following tick.
REQ-033 SHALL cover: TONE_HALF = 4, st_we with wdata = 2 -> beep next cycle; spkr toggles every 4 cycles; 2 ticks later beep = 0 and spkr = 0 within 1 cycle.
REQ-034 SHALL cover: st = 200 with spkr toggling, reset pulled low for 1 cycle -> st_value, beep and spkr read 0 in that cycle; state remains IDLE after release.
REQ-035 SHALL cover: build without CHIP8_TIMERS_TONE_EN, st_we with wdata = 1 -> spkr = 1 until the next tick, then 0.

Source files
------------

// File: rtl/chip8_pkg.sv
// ============================================================================
// Module   : chip8_pkg
// Brief    : Shared widths, default tone period and tone state encoding for
//            the CHIP-8 delay/sound timer block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip8_pkg;

    localparam int TIMER_W           = 8;
    localparam int TONE_CNT_W        = 16;
    localparam int DEFAULT_TONE_HALF = 5519;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TONE = 1'b1
    } tone_state_t;

    // A half-period shorter than 2 cycles would leave no room to count.
    function automatic int clamp_tone_half(input int half);
        return (half < 2) ? 2 : half;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chip8_timers_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Rising-edge detector on vsync; produces the 60 Hz timer tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // History of vsync; held high in reset so a high vsync at release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign tick = vsync & ~vsync_q;

endmodule

`default_nettype wire

// File: rtl/chip8_timers.sv
// ============================================================================
// Module   : chip8_timers
// Brief    : CHIP-8 delay and sound timers, decremented on vsync rising edges,
//            with beep flag and speaker drive.
//            Build option CHIP8_TIMERS_TONE_EN: when defined, spkr is a square
//            wave of TONE_HALF cycles per half-period while beeping; when not
//            defined, spkr simply follows beep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_timers
    import chip8_pkg::*;
#(
    parameter int TONE_HALF = DEFAULT_TONE_HALF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               dt_we,
    input  logic               st_we,
    input  logic [TIMER_W-1:0] wdata,
    output logic [TIMER_W-1:0] dt_value,
    output logic [TIMER_W-1:0] st_value,
    output logic               beep,
    output logic               spkr
);

    logic               tick;
    logic [TIMER_W-1:0] dt;
    logic [TIMER_W-1:0] st;

    tick_gen u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .tick  (tick)
    );

    // Delay timer: a cpu write wins over a same-cycle decrement; stops at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dt <= '0;
        end else if (dt_we) begin
            dt <= wdata;
        end else if (tick && (dt != '0)) begin
            dt <= dt - 1'b1;
        end
    end

    // Sound timer: same rules as the delay timer, fully independent of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= '0;
        end else if (st_we) begin
            st <= wdata;
        end else if (tick && (st != '0)) begin
            st <= st - 1'b1;
        end
    end

    assign dt_value = dt;
    assign st_value = st;
    assign beep     = (st != '0);

`ifdef CHIP8_TIMERS_TONE_EN

    localparam int                    TONE_HALF_EFF = clamp_tone_half(TONE_HALF);
    localparam logic [TONE_CNT_W-1:0] TONE_LAST     = TONE_CNT_W'(TONE_HALF_EFF - 1);

    tone_state_t           state;
    tone_state_t           state_next;
    logic [TONE_CNT_W-1:0] tone_cnt;
    logic [TONE_CNT_W-1:0] tone_cnt_next;
    logic                  spkr_q;
    logic                  spkr_next;

    // State register together with the tone counter and speaker flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tone_cnt <= '0;
            spkr_q   <= 1'b0;
        end else begin
            state    <= state_next;
            tone_cnt <= tone_cnt_next;
            spkr_q   <= spkr_next;
        end
    end

    // Next state: tone runs exactly while the sound timer is nonzero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beep)  state_next = TONE;
            TONE:    if (!beep) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter/speaker update; leaving TONE (or never entering) clears both,
    // so every new tone starts from phase 0 with the speaker low.
    always_comb begin
        tone_cnt_next = '0;
        spkr_next     = 1'b0;
        if ((state == TONE) && beep) begin
            if (tone_cnt == TONE_LAST) begin
                spkr_next = ~spkr_q;
            end else begin
                tone_cnt_next = tone_cnt + 1'b1;
                spkr_next     = spkr_q;
            end
        end
    end

    assign spkr = spkr_q;

`else

    // Without the tone generator the period parameter has no effect; keep
    // it referenced so a build without the option elaborates cleanly.
    if (TONE_HALF < 2) begin : g_tone_half_unused
    end

    assign spkr = beep;

`endif

endmodule

`default_nettype wire

// File: tb/tb_chip8_timers.sv
// ============================================================================
// Module   : tb_chip8_timers
// Brief    : Self-checking bench for chip8_timers (TONE_HALF = 4): directed
//            vector table, hand sequences for tone/reset corners, and a
//            randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip8_timers;

    localparam int HALF = 4;
`ifdef CHIP8_TIMERS_TONE_EN
    localparam bit TONE_EN = 1'b1;
`else
    localparam bit TONE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       dt_we;
    logic       st_we;
    logic [7:0] wdata;
    logic [7:0] dt_value;
    logic [7:0] st_value;
    logic       beep;
    logic       spkr;

    chip8_timers #(.TONE_HALF(HALF)) dut (
        .clk      (clk),
        .reset    (reset),
        .vsync    (vsync),
        .dt_we    (dt_we),
        .st_we    (st_we),
        .wdata    (wdata),
        .dt_value (dt_value),
        .st_value (st_value),
        .beep     (beep),
        .spkr     (spkr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: timer values, last vsync level, and how many
    // consecutive samples the beep has been on.
    int m_dt, m_st, m_prev_v, m_run, m_spkr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_dt = 0; m_st = 0; m_prev_v = 1; m_run = 0; m_spkr = 0;
    endtask

    task automatic model_step(input bit wd, input bit ws, input int wv, input bit vs);
        bit tick;
        int prev_run;
        tick = vs && (m_prev_v == 0);
        m_dt = wd ? wv : ((tick && m_dt > 0) ? m_dt - 1 : m_dt);
        m_st = ws ? wv : ((tick && m_st > 0) ? m_st - 1 : m_st);
        m_prev_v = vs;
        prev_run = m_run;
        m_run = (m_st != 0) ? m_run + 1 : 0;
        if (TONE_EN) m_spkr = (prev_run >= 1) ? (((prev_run - 1) / HALF) % 2) : 0;
        else         m_spkr = (m_st != 0) ? 1 : 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dt"},   dt_value, m_dt);
        check({tag, ".st"},   st_value, m_st);
        check({tag, ".beep"}, beep,     (m_st != 0) ? 1 : 0);
        check({tag, ".spkr"}, spkr,     m_spkr);
    endtask

    // One clock: drive inputs, advance model at the edge, settle past the edge.
    task automatic cycle(input bit wd, input bit ws, input logic [7:0] wv, input bit vs);
        dt_we = wd; st_we = ws; wdata = wv; vsync = vs;
        @(posedge clk);
        model_step(wd, ws, int'(wv), vs);
        #1;
    endtask

    typedef struct {
        bit       wd;
        bit       ws;
        bit [7:0] wv;
        bit       vs;
        int       e_dt;
        int       e_st;
        int       e_beep;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{0, 0,  0, 1,  0, 0, 0};  // vsync high at release: no tick
        vecs[1]  = '{0, 0,  0, 0,  0, 0, 0};
        vecs[2]  = '{1, 0,  3, 0,  3, 0, 0};  // load dt = 3
        vecs[3]  = '{0, 0,  0, 1,  2, 0, 0};
        vecs[4]  = '{0, 0,  0, 1,  2, 0, 0};  // level high, no new tick
        vecs[5]  = '{0, 0,  0, 0,  2, 0, 0};
        vecs[6]  = '{0, 0,  0, 1,  1, 0, 0};
        vecs[7]  = '{0, 0,  0, 0,  1, 0, 0};
        vecs[8]  = '{0, 0,  0, 1,  0, 0, 0};
        vecs[9]  = '{0, 0,  0, 0,  0, 0, 0};
        vecs[10] = '{0, 0,  0, 1,  0, 0, 0};  // no wrap to 255
        vecs[11] = '{0, 0,  0, 0,  0, 0, 0};
        vecs[12] = '{1, 0, 10, 1, 10, 0, 0};  // write beats same-cycle tick
        vecs[13] = '{0, 0,  0, 0, 10, 0, 0};
        vecs[14] = '{0, 0,  0, 1,  9, 0, 0};
        vecs[15] = '{1, 1,  7, 0,  7, 7, 1};  // both timers loaded together
        vecs[16] = '{0, 0,  0, 1,  6, 6, 1};
        vecs[17] = '{0, 1,  0, 0,  6, 0, 0};  // st cleared by write

        reset = 1'b0; vsync = 1'b1; dt_we = 1'b0; st_we = 1'b0; wdata = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.dt",   dt_value, 0);
        check("rst.st",   st_value, 0);
        check("rst.spkr", spkr,     0);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].wd, vecs[i].ws, vecs[i].wv, vecs[i].vs);
            check($sformatf("vec%0d.dt", i),   dt_value, vecs[i].e_dt);
            check($sformatf("vec%0d.st", i),   st_value, vecs[i].e_st);
            check($sformatf("vec%0d.beep", i), beep,     vecs[i].e_beep);
            check($sformatf("vec%0d.spkr", i), spkr,     m_spkr);
        end

        // Tone: st = 2, speaker toggles every HALF cycles once the tone starts.
        cycle(0, 1, 8'd2, 0);
        check("tone.beep_on", beep, 1);
        check("tone.s1", spkr, TONE_EN ? 0 : 1);
        for (int k = 2; k <= 13; k++) begin
            cycle(0, 0, 8'd0, 0);
            check($sformatf("tone.s%0d", k), spkr,
                  TONE_EN ? ((k >= 6 && k <= 9) ? 1 : 0) : 1);
        end
        cycle(0, 0, 8'd0, 1);
        check_model("tone.t1");
        cycle(0, 0, 8'd0, 0);
        cycle(0, 0, 8'd0, 1);
        check("tone.beep_off", beep, 0);
        cycle(0, 0, 8'd0, 0);
        check("tone.spkr_off", spkr, 0);

        // Reset mid-tone / mid-countdown.
        cycle(1, 1, 8'd200, 0);
        repeat (7) cycle(0, 0, 8'd0, 0);
        check_model("pre_rst");
        reset = 1'b0;
        model_reset();
        #1;
        check("arst.st",   st_value, 0);
        check("arst.dt",   dt_value, 0);
        check("arst.beep", beep,     0);
        check("arst.spkr", spkr,     0);
        dt_we = 1'b1; st_we = 1'b1; wdata = 8'd55; vsync = 1'b0;
        @(posedge clk);
        #1;
        check("arst.ignore_we", st_value, 0);
        reset = 1'b1;
        cycle(0, 0, 8'd0, 0);
        check_model("post_rst");
        cycle(0, 1, 8'd5, 0);
        repeat (6) begin
            cycle(0, 0, 8'd0, 0);
            check_model("restart");
        end

        // Short beep: st = 1 until the next tick.
        cycle(0, 1, 8'd0, 0);
        cycle(0, 0, 8'd0, 0);
        cycle(0, 1, 8'd1, 0);
        check("short.s1", spkr, TONE_EN ? 0 : 1);
        cycle(0, 0, 8'd0, 0);
        check("short.s2", spkr, TONE_EN ? 0 : 1);
        cycle(0, 0, 8'd0, 1);
        check("short.st", st_value, 0);
        check("short.s3", spkr, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit       r_wd, r_ws, r_vs;
            bit [7:0] r_wv;
            r_wd = ($urandom_range(0, 11) == 0);
            r_ws = ($urandom_range(0, 11) == 0);
            r_wv = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4))
                                               : 8'($urandom_range(0, 40));
            r_vs = ($urandom_range(0, 2) == 0) ? ~vsync : vsync;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check("rnd.rst_spkr", spkr, 0);
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            cycle(r_wd, r_ws, r_wv, r_vs);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
